// File: rtl/curtain_display_sequencer_if.sv
// Signal bundle between the game logic / pattern sources and the end-of-game
// display sequencer. The master drives the game and pattern inputs; the sequencer is the slave.
interface curtain_display_sequencer_if;
  logic               gameOver;
  logic               newGame;
  logic [15:0][15:0]  boardPattern;
  logic [15:0][15:0]  curtainPattern;
  logic               curtainReset;
  logic [15:0][15:0]  displayPattern;
  logic               busy;
  logic               animDone;

  modport master (
    output gameOver, newGame, boardPattern, curtainPattern,
    input  curtainReset, displayPattern, busy, animDone
  );

  modport slave (
    input  gameOver, newGame, boardPattern, curtainPattern,
    output curtainReset, displayPattern, busy, animDone
  );
endinterface

// File: rtl/curtain_display_sequencer.sv
// End-of-game LED matrix source select: live board, falling curtain, board flash,
// then frozen board until a new game starts.
module curtain_display_sequencer #(
  parameter int CURTAIN_CYCLES = 48000,
  parameter int FLASH_PERIOD   = 6000,
  parameter int FLASH_COUNT    = 6
) (
  input  logic                          clk,
  input  logic                          reset,
  curtain_display_sequencer_if.slave    bus
);

  localparam int CNT_MAX = (CURTAIN_CYCLES > FLASH_PERIOD) ? CURTAIN_CYCLES : FLASH_PERIOD;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int FN_W    = $clog2(FLASH_COUNT + 1);

  localparam logic [CNT_W-1:0] CUR_LAST = CNT_W'(CURTAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] FL_LAST  = CNT_W'(FLASH_PERIOD - 1);
  localparam logic [FN_W-1:0]  FN_LAST  = FN_W'(FLASH_COUNT - 1);

  localparam logic [1:0] S_PLAY    = 2'd0;
  localparam logic [1:0] S_CURTAIN = 2'd1;
  localparam logic [1:0] S_FLASH   = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [FN_W-1:0]   flash_num_q, flash_num_d;
  logic              blank_q, blank_d;
  logic              go_prev_q;
  logic              go_rise;

  logic              curtain_reset_q;
  logic [15:0][15:0] display_q, display_d;
  logic              busy_q;
  logic              anim_done_q;

  assign go_rise = bus.gameOver & ~go_prev_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    flash_num_d = flash_num_q;
    blank_d     = blank_q;
    if (bus.newGame) begin
      // newGame overrides everything, including a same-cycle gameOver edge
      state_d     = S_PLAY;
      cnt_d       = '0;
      flash_num_d = '0;
      blank_d     = 1'b0;
    end else begin
      case (state_q)
        S_PLAY: begin
          if (go_rise) begin
            state_d = S_CURTAIN;
            cnt_d   = '0;
          end
        end
        S_CURTAIN: begin
          if (cnt_q == CUR_LAST) begin
            state_d     = S_FLASH;
            cnt_d       = '0;
            flash_num_d = '0;
            blank_d     = 1'b0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_FLASH: begin
          if (cnt_q == FL_LAST) begin
            cnt_d       = '0;
            blank_d     = ~blank_q;
            flash_num_d = flash_num_q + 1'b1;
            if (flash_num_q == FN_LAST) state_d = S_DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_DONE:  state_d = S_DONE;
        default: state_d = S_PLAY;
      endcase
    end
  end

  // Image source follows the state of the previous cycle (one-cycle lag).
  always_comb begin
    case (state_q)
      S_CURTAIN: display_d = bus.curtainPattern;
      S_FLASH:   display_d = blank_q ? '0 : bus.boardPattern;
      default:   display_d = bus.boardPattern;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= S_PLAY;
      cnt_q           <= '0;
      flash_num_q     <= '0;
      blank_q         <= 1'b0;
      go_prev_q       <= 1'b0;
      curtain_reset_q <= 1'b1;
      display_q       <= '0;
      busy_q          <= 1'b0;
      anim_done_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      flash_num_q     <= flash_num_d;
      blank_q         <= blank_d;
      go_prev_q       <= bus.gameOver;
      curtain_reset_q <= (state_d != S_CURTAIN);
      display_q       <= display_d;
      busy_q          <= (state_d == S_CURTAIN) || (state_d == S_FLASH);
      anim_done_q     <= (state_d == S_DONE) && (state_q != S_DONE);
    end
  end

  assign bus.curtainReset   = curtain_reset_q;
  assign bus.displayPattern = display_q;
  assign bus.busy           = busy_q;
  assign bus.animDone       = anim_done_q;

endmodule

// File: tb/tb_curtain_display_sequencer.sv
// Directed bench for the curtain display sequencer with a short show
// (20 curtain cycles, 4-cycle flash half-periods, 4 half-periods).
module tb_curtain_display_sequencer;

  logic clk;
  logic reset;

  curtain_display_sequencer_if ifc ();

  curtain_display_sequencer #(
    .CURTAIN_CYCLES (20),
    .FLASH_PERIOD   (4),
    .FLASH_COUNT    (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc.slave)
  );

  localparam logic [255:0] BOARD_A = {16{16'hA5A5}};
  localparam logic [255:0] BOARD_B = {16{16'h5A5A}};
  localparam logic [255:0] CURT    = {16{16'hC3C3}};
  localparam logic [255:0] ZERO    = '0;

  int n_chk;
  int n_pass;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_crst"}, 256'(ifc.curtainReset), 256'(1'b1));
    chk({tag, "_busy"}, 256'(ifc.busy), 256'(1'b0));
    chk({tag, "_done"}, 256'(ifc.animDone), 256'(1'b0));
  endtask

  logic [255:0] exp_disp;
  logic         exp_crst, exp_busy, exp_anim;

  initial begin
    n_chk  = 0;
    n_pass = 0;
    reset  = 1'b1;
    ifc.gameOver       = 1'b0;
    ifc.newGame        = 1'b0;
    ifc.boardPattern   = BOARD_A;
    ifc.curtainPattern = CURT;

    // 1: reset state and board pass-through
    step(); step();
    chk("rst_disp", ifc.displayPattern, ZERO);
    chk_idle("rst");
    reset = 1'b0;
    step();
    chk("play_disp_a", ifc.displayPattern, BOARD_A);
    chk_idle("play");
    ifc.boardPattern = BOARD_B;
    #2;
    chk("play_lag", ifc.displayPattern, BOARD_A);
    step();
    chk("play_disp_b", ifc.displayPattern, BOARD_B);
    ifc.boardPattern = BOARD_A;
    step();

    // 2/3: full show, k = edges after the edge that samples the rise
    ifc.gameOver = 1'b1;
    step();
    chk("go_crst", 256'(ifc.curtainReset), 256'(1'b0));
    chk("go_busy", 256'(ifc.busy), 256'(1'b1));
    chk("go_disp", ifc.displayPattern, BOARD_A);
    for (int k = 1; k <= 38; k++) begin
      step();
      exp_crst = (k >= 20);
      exp_busy = (k <= 35);
      exp_anim = (k == 36);
      if (k <= 20)      exp_disp = CURT;
      else if (k <= 24) exp_disp = BOARD_A;
      else if (k <= 28) exp_disp = ZERO;
      else if (k <= 32) exp_disp = BOARD_A;
      else if (k <= 36) exp_disp = ZERO;
      else              exp_disp = BOARD_A;
      chk($sformatf("show_crst_k%0d", k), 256'(ifc.curtainReset), 256'(exp_crst));
      chk($sformatf("show_busy_k%0d", k), 256'(ifc.busy), 256'(exp_busy));
      chk($sformatf("show_done_k%0d", k), 256'(ifc.animDone), 256'(exp_anim));
      chk($sformatf("show_disp_k%0d", k), ifc.displayPattern, exp_disp);
    end

    // 4: DONE holds with gameOver high, restart needs newGame then a fresh rise
    for (int i = 0; i < 50; i++) step();
    chk_idle("done_hold");
    chk("done_disp", ifc.displayPattern, BOARD_A);
    ifc.gameOver = 1'b0;
    step();
    ifc.newGame = 1'b1;
    step();
    ifc.newGame = 1'b0;
    step();
    chk_idle("after_ng");
    ifc.gameOver = 1'b1;
    step();
    chk("restart_crst", 256'(ifc.curtainReset), 256'(1'b0));
    chk("restart_busy", 256'(ifc.busy), 256'(1'b1));

    // 5: abort at cnt==7, then newGame coinciding with a rise
    for (int i = 0; i < 7; i++) step();
    chk("abort_pre_crst", 256'(ifc.curtainReset), 256'(1'b0));
    ifc.newGame = 1'b1;
    step();
    ifc.newGame = 1'b0;
    chk_idle("abort");
    for (int i = 0; i < 30; i++) begin
      step();
      chk($sformatf("abort_idle_done_%0d", i), 256'(ifc.animDone), 256'(1'b0));
    end
    chk_idle("abort_end");
    chk("abort_disp", ifc.displayPattern, BOARD_A);
    ifc.gameOver = 1'b0;
    step();
    ifc.gameOver = 1'b1;
    ifc.newGame  = 1'b1;
    step();
    ifc.newGame = 1'b0;
    chk_idle("ng_rise_0");
    for (int i = 0; i < 5; i++) step();
    chk_idle("ng_rise_5");

    // 6: async reset in FLASH, observed before the next clock edge
    ifc.gameOver = 1'b0;
    step();
    ifc.gameOver = 1'b1;
    step();
    for (int i = 0; i < 25; i++) step();
    chk("flash_busy", 256'(ifc.busy), 256'(1'b1));
    chk("flash_crst", 256'(ifc.curtainReset), 256'(1'b1));
    #2;
    reset = 1'b1;
    #1;
    chk("arst_disp", ifc.displayPattern, ZERO);
    chk_idle("arst");
    ifc.gameOver = 1'b0;
    step();
    reset = 1'b0;
    step();
    chk_idle("post_arst");
    chk("post_arst_disp", ifc.displayPattern, BOARD_A);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
